img1bit_morph3x3: RTL
=====================

// Module: img1bit_morph3x3
// PURPOSE
//  Run-time configurable 3x3 binary morphology stage for the 1-bit motion-mask path (diff -> morphology -> isp_1bit_out).
//  One parametrised instance does the work of a fixed erosion or dilation stage, and adds pass-through and majority modes.
//  Mode is frame-synchronous: it changes only at a frame boundary, never mid-frame.
//  Instances are chained to build open/close sequences.
// PARAMETERS
//  IMG_WIDTH   640  active pixels per line
//  IMG_HEIGHT  480  active lines per frame; used only for frame_done
//  COL_W       10   column counter width; must satisfy 2**COL_W > IMG_WIDTH
//  ROW_W       9    row counter width; must satisfy 2**ROW_W >= IMG_HEIGHT
//  MAJ_THR     5    majority mode: output 1 when popcount(window) >= MAJ_THR (1..9)
//  BORDER_VAL  1'b0 output value wherever the window leaves the image
// PORTS
//  sys_clk        in   1   pixel clock
//  sys_rst        in   1   synchronous, active-high reset
//  mode           in   2   00 pass, 01 erode (AND-9), 10 dilate (OR-9), 11 majority
//  pre_vsync      in   1   input frame sync, active high
//  pre_href       in   1   input line valid
//  pre_wr_en      in   1   input pixel valid
//  img_1bit_in    in   1   input mask pixel
//  post_vsync     out  1   pre_vsync delayed 3 clocks
//  post_href      out  1   pre_href delayed 3 clocks
//  post_wr_en     out  1   pre_wr_en delayed 3 clocks
//  img_1bit_out   out  1   result pixel
//  post_rgb565    out  16  16'hFFFF when img_1bit_out=1, else 16'h0000
//  frame_done     out  1   1-clock pulse with the output of the last pixel of row IMG_HEIGHT-1
//  line_ovf       out  1   sticky: a line carried more than IMG_WIDTH pixels
// BEHAVIOUR
//  Reset (sys_rst=1 at a clock edge):
//   - All outputs go to 0.
//   - col/row counters go to 0; mode_q goes to 2'b00.
//   - The 3-stage sync pipe is flushed to 0.
//   - Line buffers are not cleared; the border rule masks their contents.
//  Reset asserted mid-frame:
//   - Outputs go to 0 on the next edge.
//   - After release, output resumes only after the next pre_vsync rising edge.
//   - Until that edge, post_wr_en stays 0 even if pre_wr_en toggles.
//  Frame/mode handling:
//   - On a pre_vsync rising edge: mode_q <= mode, row <= 0, col <= 0, line_ovf <= 0.
//   - Changes on mode at any other time are ignored until the next frame.
//  Counters:
//   - col increments on each pre_wr_en.
//   - On a pre_href falling edge: col <= 0 and row <= row+1 (row saturates at 2**ROW_W-1).
//  Line buffers:
//   - Two IMG_WIDTH x 1 buffers (RAM or shift registers), addressed by col.
//   - On pre_wr_en: lb1[col] <= lb0[col] and lb0[col] <= img_1bit_in.
//   - The read of the old value and the write occur in the same cycle (read-before-write).
//  Window:
//   - Three 3-bit shift registers, one each for rows r-2, r-1 and r, advanced only on pre_wr_en.
//   - The output at input position (r,c) is computed over rows r-2..r and cols c-2..c, centre (r-1,c-1).
//   - The mask image therefore shifts one pixel down-right. This is intended and matches the colour path alignment.
//  Ops (3'b window rows w2,w1,w0):
//   - pass: centre bit w1[1].
//   - erode: &{w2,w1,w0}.
//   - dilate: |{w2,w1,w0}.
//   - majority: popcount of the 9 bits (4-bit adder tree) >= MAJ_THR.
//  Border: if r<2 or c<2, img_1bit_out = BORDER_VAL in every mode, including pass.
//  Latency: a pixel sampled with pre_wr_en at cycle t appears with post_wr_en at t+3.
//   - Stage 1: buffer read / window shift.
//   - Stage 2: op and border select.
//   - Stage 3: output register.
//   - vsync, href and wr_en pass through a matched 3-deep delay.
//   - img_1bit_out and post_rgb565 are held when post_wr_en=0.
//  Overflow:
//   - A pre_wr_en while col == IMG_WIDTH sets line_ovf.
//   - That pixel does not write the buffers; col holds at IMG_WIDTH.
//   - The pixel is still output, with value BORDER_VAL.
//  Simultaneous pre_vsync rise and pre_wr_en: the frame reset has priority; the pixel counts as (0,0).
//  Back-to-back pixels every clock are supported; gaps of any length between pixels are allowed.
// TESTING
//  1. Reset, then idle.
//     -> All outputs 0; post_rgb565 = 16'h0000 for 10 clocks after release.
//  2. Erode, 8x8 frame (IMG_WIDTH=8, IMG_HEIGHT=8), white 5x5 square at (1..5,1..5).
//     -> Output 1 only at input positions (3..5,3..5), i.e. a 3x3 block.
//  3. Dilate, single 1 at (4,4).
//     -> Output 1 at input positions (4..6,4..6); post_wr_en lags pre_wr_en by exactly 3 clocks.
//  4. Majority, MAJ_THR=5, checkerboard 3x3 patches holding 5 and 4 ones.
//     -> Outputs 1 and 0 respectively.
//  5. mode switched from 01 to 10 mid-frame.
//     -> Erode results for the rest of that frame; dilate from the next pre_vsync rise.
//  6. Line of 9 pixels with IMG_WIDTH=8.
//     -> line_ovf=1, 9th output = BORDER_VAL, next line unaffected; line_ovf clears on the next vsync rise.
//     Repeat with sys_rst pulsed mid-frame -> no post_wr_en until the next vsync.

Source files
------------

// File: rtl/img1bit_morph3x3.sv
// Run-time configurable 3x3 binary morphology (pass / erode / dilate / majority) for a 1-bit mask stream.
// Three-clock pipeline with a matched sync delay, frame-synchronous mode latch and line-overflow flag.
module img1bit_morph3x3 #(
  parameter int   IMG_WIDTH  = 640,
  parameter int   IMG_HEIGHT = 480,
  parameter int   COL_W      = 10,
  parameter int   ROW_W      = 9,
  parameter int   MAJ_THR    = 5,
  parameter logic BORDER_VAL = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  mode,
  input  logic        pre_vsync,
  input  logic        pre_href,
  input  logic        pre_wr_en,
  input  logic        img_1bit_in,
  output logic        post_vsync,
  output logic        post_href,
  output logic        post_wr_en,
  output logic        img_1bit_out,
  output logic [15:0] post_rgb565,
  output logic        frame_done,
  output logic        line_ovf
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_END  = COL_W'(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = '1;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_ERODE  = 2'b01,
    MODE_DILATE = 2'b10,
    MODE_MAJ    = 2'b11
  } mode_e;

  // Frame / line state
  logic             vsync_prev_q, href_prev_q;
  logic             armed_q, armed_d;
  mode_e            mode_q, mode_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             line_ovf_q, line_ovf_d;

  // Pipeline
  logic [2:0]       vs_pipe_q, hr_pipe_q;
  logic             v1_q, b1_q, last1_q;
  mode_e            m1_q;
  logic             v2_q, res2_q, last2_q;
  logic             wr_en_q, out_q, frame_done_q;

  // Line buffers and window
  logic             lb0_q [IMG_WIDTH];
  logic             lb1_q [IMG_WIDTH];
  logic [2:0]       w2_q, w1_q, w0_q;

  logic             vs_rise, href_fall, pix_ok, in_range, wr;
  logic [COL_W-1:0] col_eff;
  logic [ROW_W-1:0] row_eff;
  mode_e            mode_eff;
  logic [AW-1:0]    lb_addr;
  logic [1:0]       s2, s1, s0;
  logic [3:0]       pop;
  logic             op;

  // A pixel arriving with the vsync rise belongs to the new frame at (0,0).
  assign vs_rise   = pre_vsync & ~vsync_prev_q;
  assign href_fall = ~pre_href & href_prev_q;
  assign col_eff   = vs_rise ? '0 : col_q;
  assign row_eff   = vs_rise ? '0 : row_q;
  assign mode_eff  = vs_rise ? mode_e'(mode) : mode_q;
  assign pix_ok    = pre_wr_en & (armed_q | vs_rise);
  assign in_range  = (col_eff != COL_END);
  assign wr        = pix_ok & in_range;
  assign lb_addr   = col_eff[AW-1:0];

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    col_d      = col_q;
    row_d      = row_q;
    mode_d     = mode_q;
    line_ovf_d = line_ovf_q;
    armed_d    = armed_q;
    if (vs_rise) begin
      col_d      = COL_W'(wr);
      row_d      = '0;
      mode_d     = mode_e'(mode);
      line_ovf_d = 1'b0;
      armed_d    = 1'b1;
    end else begin
      if (href_fall) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? row_q : row_q + 1'b1;
      end else if (wr) begin
        col_d = col_q + 1'b1;
      end
      if (pix_ok && !in_range) line_ovf_d = 1'b1;
    end
  end

  always_comb begin
    s2  = {1'b0, w2_q[0]} + {1'b0, w2_q[1]} + {1'b0, w2_q[2]};
    s1  = {1'b0, w1_q[0]} + {1'b0, w1_q[1]} + {1'b0, w1_q[2]};
    s0  = {1'b0, w0_q[0]} + {1'b0, w0_q[1]} + {1'b0, w0_q[2]};
    pop = {2'b00, s2} + {2'b00, s1} + {2'b00, s0};
    op  = 1'b0;
    unique case (m1_q)
      MODE_PASS:   op = w1_q[1];
      MODE_ERODE:  op = &{w2_q, w1_q, w0_q};
      MODE_DILATE: op = |{w2_q, w1_q, w0_q};
      MODE_MAJ:    op = (pop >= 4'(MAJ_THR));
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      mode_q       <= MODE_PASS;
      col_q        <= '0;
      row_q        <= '0;
      line_ovf_q   <= 1'b0;
      vs_pipe_q    <= '0;
      hr_pipe_q    <= '0;
      v1_q         <= 1'b0;
      b1_q         <= 1'b0;
      last1_q      <= 1'b0;
      m1_q         <= MODE_PASS;
      v2_q         <= 1'b0;
      res2_q       <= 1'b0;
      last2_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      out_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      vsync_prev_q <= pre_vsync;
      href_prev_q  <= pre_href;
      armed_q      <= armed_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      row_q        <= row_d;
      line_ovf_q   <= line_ovf_d;
      vs_pipe_q    <= {vs_pipe_q[1:0], pre_vsync};
      hr_pipe_q    <= {hr_pipe_q[1:0], pre_href};
      // Stage 1: window shift (below) plus per-pixel position flags
      v1_q         <= pix_ok;
      b1_q         <= !in_range || (row_eff < ROW_W'(2)) || (col_eff < COL_W'(2));
      last1_q      <= in_range && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      m1_q         <= mode_eff;
      // Stage 2: operator and border select
      v2_q         <= v1_q;
      last2_q      <= v1_q & last1_q;
      if (v1_q) res2_q <= b1_q ? BORDER_VAL : op;
      // Stage 3: output register, held between pixels
      wr_en_q      <= v2_q;
      frame_done_q <= v2_q & last2_q;
      if (v2_q) out_q <= res2_q;
    end
  end

  // NOTE: line buffers and window carry no reset; the border rule masks stale contents.
  always_ff @(posedge sys_clk) begin
    if (wr) begin
      lb0_q[lb_addr] <= img_1bit_in;
      lb1_q[lb_addr] <= lb0_q[lb_addr];
      w2_q           <= {w2_q[1:0], lb1_q[lb_addr]};
      w1_q           <= {w1_q[1:0], lb0_q[lb_addr]};
      w0_q           <= {w0_q[1:0], img_1bit_in};
    end
  end

  assign post_vsync   = vs_pipe_q[2];
  assign post_href    = hr_pipe_q[2];
  assign post_wr_en   = wr_en_q;
  assign img_1bit_out = out_q;
  assign post_rgb565  = {16{out_q}};
  assign frame_done   = frame_done_q;
  assign line_ovf     = line_ovf_q;

endmodule
